vector_issue_queue: RTL and testbench

//  In-order issue buffer between scalar decode and vector_ex. Queues decoded vector instructions,

---
 rtl/vector_issue_queue.sv | 222 ++++++++++++++++++++++
 tb/tb_vector_issue_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_issue_queue.sv
// rtl/vector_issue_queue.sv - in-order vector issue buffer; owns vsetvli config, pulses ops to vector_ex.
// Optional VISSUE_BYPASS_EN: an instruction arriving at an idle, empty queue skips the FIFO.
module vector_issue_queue #(
    parameter int VLEN  = 128,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [6:0]  i_ops,
    input  logic [5:0]  i_funct6,
    input  logic [2:0]  i_funct3,
    input  logic [10:0] i_zimm,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [4:0]  i_vs1a,
    input  logic [4:0]  i_vs2a,
    input  logic [4:0]  i_vs3a,
    input  logic        i_ex_busy,
    output logic [6:0]  o_ops,
    output logic [5:0]  o_funct6,
    output logic [2:0]  o_funct3,
    output logic [31:0] o_rs1,
    output logic [31:0] o_rs2,
    output logic [4:0]  o_vs1a,
    output logic [4:0]  o_vs2a,
    output logic [4:0]  o_vs3a,
    output logic [10:0] o_sew,
    output logic [3:0]  o_lmul,
    output logic [31:0] o_venum,
    output logic        o_vl_we,
    output logic [31:0] o_vl_data,
    output logic        o_busy
);

    localparam int AW = $clog2(DEPTH);

    // Only vsew/vlmul of the vtype immediate are consumed; tail/mask policy bits are ignored.
    typedef struct packed {
        logic [6:0]  ops;
        logic [5:0]  funct6;
        logic [2:0]  funct3;
        logic [5:0]  vtype;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  vs1a;
        logic [4:0]  vs2a;
        logic [4:0]  vs3a;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CFG   = 2'd1,
        WBSY  = 2'd2,
        WDONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    instr_t      mem_q [DEPTH];
    logic [AW:0] rd_ptr_q, wr_ptr_q;
    instr_t      in_instr, head, sel;
    logic        empty, full, push, pop, bypass, issue, cfg_load, fifo_wr;
    logic        unused_zimm_hi;

    logic [6:0]  ops_q;
    logic [5:0]  funct6_q;
    logic [2:0]  funct3_q;
    logic [31:0] rs1_q, rs2_q;
    logic [4:0]  vs1a_q, vs2a_q, vs3a_q;

    logic [5:0]  cfg_vtype_q;
    logic [31:0] cfg_rs1_q;
    logic [4:0]  cfg_vs1a_q, cfg_vs3a_q;

    logic [10:0] sew_q, new_sew;
    logic [3:0]  lmul_q, new_lmul;
    logic [31:0] venum_q, vl_data_q, vlmax, avl, new_vl;
    logic        vl_we_q;
    logic [2:0]  vsew, vlmul;
    logic [1:0]  sew_sh;
    logic [2:0]  log2_sew;

    assign unused_zimm_hi = ^i_zimm[10:6];

    assign in_instr = '{ops: i_ops, funct6: i_funct6, funct3: i_funct3, vtype: i_zimm[5:0],
                        rs1: i_rs1, rs2: i_rs2, vs1a: i_vs1a, vs2a: i_vs2a, vs3a: i_vs3a};
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign empty    = (rd_ptr_q == wr_ptr_q);
    assign full     = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    assign o_ready  = !full;
    assign push     = i_valid && !full;
    assign fifo_wr  = push && !bypass;

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        bypass   = 1'b0;
        issue    = 1'b0;
        cfg_load = 1'b0;
        sel      = head;
        case (state_q)
            IDLE: begin
                if (!empty && !i_ex_busy) begin
                    pop = 1'b1;
                end
`ifdef VISSUE_BYPASS_EN
                else if (empty && !i_ex_busy && push) begin
                    bypass = 1'b1;
                    sel    = in_instr;
                end
`endif
                if (pop || bypass) begin
                    if (sel.ops == 7'h57 && sel.funct3 == 3'b111) begin
                        cfg_load = 1'b1;
                        state_d  = CFG;
                    end else begin
                        issue   = 1'b1;
                        state_d = WBSY;
                    end
                end
            end
            CFG:     state_d = IDLE;
            WBSY:    if (i_ex_busy)  state_d = WDONE;
            WDONE:   if (!i_ex_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Config arithmetic works from the vsetvli captured when it left the queue.
    always_comb begin
        vsew     = cfg_vtype_q[5:3];
        vlmul    = cfg_vtype_q[2:0];
        sew_sh   = (vsew > 3'd3) ? 2'd3 : vsew[1:0];
        log2_sew = 3'd3 + {1'b0, sew_sh};
        new_sew  = 11'd8 << sew_sh;
        new_lmul = vlmul[2] ? 4'd0 : ((4'd1 << vlmul[1:0]) - 4'd1);
        vlmax    = (32'(VLEN) * (32'(new_lmul) + 32'd1)) >> log2_sew;
        if (cfg_vs1a_q != 5'd0) begin
            avl = cfg_rs1_q;
        end else if (cfg_vs3a_q != 5'd0) begin
            avl = vlmax;
        end else begin
            avl = venum_q;
        end
        new_vl = (avl < vlmax) ? avl : vlmax;
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            ops_q       <= '0;
            funct6_q    <= '0;
            funct3_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            vs1a_q      <= '0;
            vs2a_q      <= '0;
            vs3a_q      <= '0;
            cfg_vtype_q <= '0;
            cfg_rs1_q   <= '0;
            cfg_vs1a_q  <= '0;
            cfg_vs3a_q  <= '0;
            sew_q       <= 11'd8;
            lmul_q      <= '0;
            venum_q     <= '0;
            vl_data_q   <= '0;
            vl_we_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            ops_q <= issue ? sel.ops : 7'd0;
            if (issue) begin
                funct6_q <= sel.funct6;
                funct3_q <= sel.funct3;
                rs1_q    <= sel.rs1;
                rs2_q    <= sel.rs2;
                vs1a_q   <= sel.vs1a;
                vs2a_q   <= sel.vs2a;
                vs3a_q   <= sel.vs3a;
            end
            if (cfg_load) begin
                cfg_vtype_q <= sel.vtype;
                cfg_rs1_q   <= sel.rs1;
                cfg_vs1a_q  <= sel.vs1a;
                cfg_vs3a_q  <= sel.vs3a;
            end
            vl_we_q <= (state_q == CFG);
            if (state_q == CFG) begin
                sew_q     <= new_sew;
                lmul_q    <= new_lmul;
                venum_q   <= new_vl;
                vl_data_q <= new_vl;
            end
        end
    end

    assign o_ops     = ops_q;
    assign o_funct6  = funct6_q;
    assign o_funct3  = funct3_q;
    assign o_rs1     = rs1_q;
    assign o_rs2     = rs2_q;
    assign o_vs1a    = vs1a_q;
    assign o_vs2a    = vs2a_q;
    assign o_vs3a    = vs3a_q;
    assign o_sew     = sew_q;
    assign o_lmul    = lmul_q;
    assign o_venum   = venum_q;
    assign o_vl_we   = vl_we_q;
    assign o_vl_data = vl_data_q;
    assign o_busy    = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_vector_issue_queue.sv
// tb/tb_vector_issue_queue.sv - directed self-checking bench for vector_issue_queue.
module tb_vector_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, o_ready, i_ex_busy, o_vl_we, o_busy;
    logic [6:0]  i_ops, o_ops;
    logic [5:0]  i_funct6, o_funct6;
    logic [2:0]  i_funct3, o_funct3;
    logic [10:0] i_zimm, o_sew;
    logic [31:0] i_rs1, i_rs2, o_rs1, o_rs2, o_venum, o_vl_data;
    logic [4:0]  i_vs1a, i_vs2a, i_vs3a, o_vs1a, o_vs2a, o_vs3a;
    logic [3:0]  o_lmul;

`ifdef VISSUE_BYPASS_EN
    localparam int EXP_OP_LAT  = 1;
    localparam int EXP_CFG_LAT = 1;
`else
    localparam int EXP_OP_LAT  = 2;
    localparam int EXP_CFG_LAT = 2;
`endif

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    logic ex_hold  = 1'b0;
    logic ex_en    = 1'b0;
    int   ex_cnt   = 0;

    always #5 clk = ~clk;

    vector_issue_queue #(.VLEN(128), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_ops(i_ops), .i_funct6(i_funct6), .i_funct3(i_funct3), .i_zimm(i_zimm),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_vs1a(i_vs1a), .i_vs2a(i_vs2a), .i_vs3a(i_vs3a),
        .i_ex_busy(i_ex_busy), .o_ops(o_ops), .o_funct6(o_funct6), .o_funct3(o_funct3),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_vs1a(o_vs1a), .o_vs2a(o_vs2a), .o_vs3a(o_vs3a),
        .o_sew(o_sew), .o_lmul(o_lmul), .o_venum(o_venum), .o_vl_we(o_vl_we),
        .o_vl_data(o_vl_data), .o_busy(o_busy)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // vector_ex stand-in: busy for 3 cycles starting the cycle after each o_ops pulse.
    initial begin
        i_ex_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ex_hold) begin
                i_ex_busy = 1'b1;
            end else if (ex_en && ex_cnt > 0) begin
                i_ex_busy = 1'b1;
                ex_cnt--;
            end else begin
                i_ex_busy = 1'b0;
                ex_cnt    = 0;
            end
            if (ex_en && o_ops != 7'd0) ex_cnt = 3;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] ops, input logic [5:0] f6, input logic [2:0] f3,
                             input logic [10:0] zimm, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vs3);
        i_ops = ops; i_funct6 = f6; i_funct3 = f3; i_zimm = zimm;
        i_rs1 = rs1; i_rs2 = rs2; i_vs1a = vs1; i_vs2a = vs2; i_vs3a = vs3;
    endtask

    task automatic push_one(input logic [6:0] ops, input logic [5:0] f6, input logic [2:0] f3,
                            input logic [10:0] zimm, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vs3);
        int w;
        set_instr(ops, f6, f3, zimm, rs1, rs2, vs1, vs2, vs3);
        i_valid = 1'b1;
        w = 0;
        while (!o_ready && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) check("push_ready_timeout", 64'd0, 64'd1);
        step();
        i_valid = 1'b0;
    endtask

    task automatic do_vset(input string tag, input logic [10:0] zimm, input logic [31:0] rs1,
                           input logic [4:0] vs1, input logic [4:0] vs3,
                           input int exp_sew, input int exp_lmul, input int exp_vl);
        int lat;
        push_one(7'h57, 6'd0, 3'b111, zimm, rs1, 32'd0, vs1, 5'd0, vs3);
        lat = 0;
        while (!o_vl_we && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(EXP_CFG_LAT));
        check({tag, "_sew"}, 64'(o_sew), 64'(exp_sew));
        check({tag, "_lmul"}, 64'(o_lmul), 64'(exp_lmul));
        check({tag, "_venum"}, 64'(o_venum), 64'(exp_vl));
        check({tag, "_vldata"}, 64'(o_vl_data), 64'(exp_vl));
        step();
        check({tag, "_we_pulse"}, 64'(o_vl_we), 64'd0);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((o_busy || i_ex_busy) && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) check("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, p1, got, last;
        logic acc, seen;
        rst = 1'b1;
        i_valid = 1'b0;
        set_instr(7'd0, 6'd0, 3'd0, 11'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_ops", 64'(o_ops), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_sew", 64'(o_sew), 64'd8);
        check("rst_lmul", 64'(o_lmul), 64'd0);
        check("rst_venum", 64'(o_venum), 64'd0);
        check("rst_vl_we", 64'(o_vl_we), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_rs1", 64'(o_rs1), 64'd0);

        ex_en = 1'b1;
        do_vset("frac", 11'h01C, 32'd100, 5'd1, 5'd2, 64, 0, 2);
        do_vset("sewclamp", 11'h020, 32'd1, 5'd1, 5'd2, 64, 0, 1);
        do_vset("vlmax", 11'h003, 32'd7, 5'd0, 5'd5, 8, 7, 128);
        do_vset("avl5", 11'h002, 32'd5, 5'd1, 5'd2, 8, 3, 5);
        do_vset("keepvl", 11'h00B, 32'd99, 5'd0, 5'd0, 16, 7, 5);
        do_vset("e32m2", 11'h011, 32'd20, 5'd1, 5'd4, 32, 1, 8);

        // Single op from an empty, idle queue.
        push_one(7'h57, 6'h09, 3'b000, 11'd0, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3);
        lat = 1;
        while (o_ops == 7'd0 && lat < 20) begin
            step();
            lat++;
        end
        check("lat_issue", 64'(lat), 64'(EXP_OP_LAT));
        wait_idle();

        // Two back-to-back ops: field contents, one-cycle pulse, issue spacing.
        push_one(7'h57, 6'h11, 3'b000, 11'd0, 32'hA5A5_0001, 32'h1234_5678, 5'd3, 5'd4, 5'd5);
        push_one(7'h07, 6'h22, 3'b110, 11'd0, 32'h0000_0100, 32'h0, 5'd6, 5'd7, 5'd8);
        lat = 0;
        while (o_ops == 7'd0 && lat < 20) begin
            step();
            lat++;
        end
        p1 = cyc;
        check("a_ops", 64'(o_ops), 64'h57);
        check("a_funct6", 64'(o_funct6), 64'h11);
        check("a_rs1", 64'(o_rs1), 64'hA5A5_0001);
        check("a_rs2", 64'(o_rs2), 64'h1234_5678);
        check("a_vregs", 64'({o_vs1a, o_vs2a, o_vs3a}), 64'({5'd3, 5'd4, 5'd5}));
        check("a_sew_run", 64'(o_sew), 64'd32);
        step();
        check("a_pulse_end", 64'(o_ops), 64'd0);
        check("a_rs1_held", 64'(o_rs1), 64'hA5A5_0001);
        lat = 0;
        while (o_ops == 7'd0 && lat < 30) begin
            step();
            lat++;
        end
        check("b_ops", 64'(o_ops), 64'h07);
        check("b_funct3", 64'(o_funct3), 64'd6);
        check("b_gap", 64'(cyc - p1), 64'd6);
        wait_idle();

        // Fill the queue while vector_ex is busy, then drain in order.
        ex_hold = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            push_one(7'h57, 6'(i + 1), 3'b000, 11'd0, 32'(i), 32'd0, 5'd1, 5'd1, 5'd1);
        end
        check("full_ready", 64'(o_ready), 64'd0);
        set_instr(7'h57, 6'd5, 3'b000, 11'd0, 32'd4, 32'd0, 5'd1, 5'd1, 5'd1);
        i_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (o_ops != 7'd0) seen = 1'b1;
        end
        check("hold_no_issue", 64'(seen), 64'd0);
        check("hold_ready", 64'(o_ready), 64'd0);
        ex_hold = 1'b0;
        got = 0;
        last = 0;
        for (int k = 0; k < 80 && got < 5; k++) begin
            acc = i_valid && o_ready;
            step();
            if (acc) i_valid = 1'b0;
            if (o_ops != 7'd0) begin
                check("drain_order", 64'(o_funct6), 64'(got + 1));
                if (got > 0) check("drain_gap", 64'(cyc - last), 64'd6);
                last = cyc;
                got++;
            end
        end
        check("drain_count", 64'(got), 64'd5);
        i_valid = 1'b0;
        wait_idle();

        // Reset while stuck waiting for busy, with three ops still queued.
        ex_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_one(7'h57, 6'(i + 8), 3'b000, 11'd0, 32'd0, 32'd0, 5'd1, 5'd1, 5'd1);
        end
        check("pre_rst_busy", 64'(o_busy), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_ops", 64'(o_ops), 64'd0);
        check("mid_rst_busy", 64'(o_busy), 64'd0);
        check("mid_rst_sew", 64'(o_sew), 64'd8);
        check("mid_rst_lmul", 64'(o_lmul), 64'd0);
        check("mid_rst_venum", 64'(o_venum), 64'd0);
        check("mid_rst_ready", 64'(o_ready), 64'd1);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (o_ops != 7'd0 || o_busy) seen = 1'b1;
        end
        check("post_rst_quiet", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
